// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - byte/halfword/word load unit with sign/zero extension
// Optional feature: define LOAD_MISALIGN_TRAP_EN to reject misaligned LH/LHU/LW with ld_err.
module mem_load_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [2:0]        ld_type,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic              ld_err
);

   localparam logic [2:0] T_LB  = 3'b000;
   localparam logic [2:0] T_LBU = 3'b001;
   localparam logic [2:0] T_LH  = 3'b010;
   localparam logic [2:0] T_LHU = 3'b011;
   localparam logic [2:0] T_LW  = 3'b100;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  type_q;
   logic [1:0]  off_q;
   logic        accept;
   logic        reject;
   logic        bad_req;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext_data;

   // A request is rejected for an illegal type, and optionally for misalignment
   always_comb begin
      bad_req = (ld_type > T_LW);
`ifdef LOAD_MISALIGN_TRAP_EN
      if (((ld_type == T_LH) || (ld_type == T_LHU)) && ld_addr[0])
         bad_req = 1'b1;
      if ((ld_type == T_LW) && (ld_addr[1:0] != 2'b00))
         bad_req = 1'b1;
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and handshake outputs; rejected requests stay in IDLE
   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      mem_req   = 1'b0;
      rd_valid  = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               if (bad_req) begin
                  reject = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_nxt = DONE;
         end
         DONE: begin
            rd_valid  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Lane select and extension of the returned word by the latched type/offset
   always_comb begin
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (type_q)
         T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         T_LBU:   ext_data = {24'd0, byte_sel};
         T_LH:    ext_data = {{16{half_sel[15]}}, half_sel};
         T_LHU:   ext_data = {16'd0, half_sel};
         default: ext_data = mem_rdata;
      endcase
   end

   // Request latch, word-aligned address, result capture and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q   <= T_LB;
         off_q    <= 2'd0;
         mem_addr <= '0;
         rd_data  <= 32'd0;
         ld_err   <= 1'b0;
      end else begin
         ld_err <= reject;
         if (accept) begin
            type_q   <= ld_type;
            off_q    <= ld_addr[1:0];
            mem_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
         end
         if ((state == REQ) && mem_ack)
            rd_data <= ext_data;
      end
   end

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - directed table-driven bench for mem_load_unit
module tb_mem_load_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_type;
   logic [31:0] ld_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        ld_err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          delay;
      logic        err;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        vecs[14];
   logic [31:0] last_good;

   mem_load_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_type(ld_type), .ld_addr(ld_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rd_valid(rd_valid),
      .rd_data(rd_data), .ld_err(ld_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [31:0] want;
      @(negedge clk);
      check($sformatf("v%0d ready", idx), {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_type  = v.typ;
      ld_addr  = v.addr;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      if (v.err) begin
         @(negedge clk);
         check($sformatf("v%0d err", idx), {31'd0, ld_err}, 32'd1);
         check($sformatf("v%0d no req", idx), {31'd0, mem_req}, 32'd0);
         @(negedge clk);
         check($sformatf("v%0d err end", idx), {31'd0, ld_err}, 32'd0);
         check($sformatf("v%0d ready after err", idx), {31'd0, ld_ready}, 32'd1);
         check($sformatf("v%0d data kept", idx), rd_data, last_good);
      end else begin
         want = v.exp_data;
         for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            check($sformatf("v%0d wait req", idx), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d wait addr", idx), mem_addr, v.exp_addr);
            check($sformatf("v%0d wait busy", idx), {31'd0, ld_ready}, 32'd0);
         end
         @(negedge clk);
         check($sformatf("v%0d req", idx), {31'd0, mem_req}, 32'd1);
         check($sformatf("v%0d addr", idx), mem_addr, v.exp_addr);
         check($sformatf("v%0d no err", idx), {31'd0, ld_err}, 32'd0);
         mem_ack   = 1'b1;
         mem_rdata = v.rdata;
         @(posedge clk);
         #1 mem_ack = 1'b0;
         mem_rdata = 32'h0;
         @(negedge clk);
         check($sformatf("v%0d rd_valid", idx), {31'd0, rd_valid}, 32'd1);
         check($sformatf("v%0d rd_data", idx), rd_data, want);
         check($sformatf("v%0d done busy", idx), {31'd0, ld_ready}, 32'd0);
         @(negedge clk);
         check($sformatf("v%0d rd_valid end", idx), {31'd0, rd_valid}, 32'd0);
         check($sformatf("v%0d idle", idx), {31'd0, ld_ready}, 32'd1);
         last_good = want;
      end
   endtask

   initial begin
      vecs[0]  = '{3'b000, 32'h103, 32'h80ABCD12, 0, 1'b0, 32'h100, 32'hFFFFFF80};
      vecs[1]  = '{3'b011, 32'h202, 32'h9ABC1234, 1, 1'b0, 32'h200, 32'h00009ABC};
      vecs[2]  = '{3'b010, 32'h202, 32'h9ABC1234, 0, 1'b0, 32'h200, 32'hFFFF9ABC};
      vecs[3]  = '{3'b100, 32'h040, 32'h12345678, 5, 1'b0, 32'h040, 32'h12345678};
      vecs[4]  = '{3'b111, 32'h010, 32'h0,        0, 1'b1, 32'h0,   32'h0};
      vecs[5]  = '{3'b001, 32'h101, 32'h80ABCD12, 0, 1'b0, 32'h100, 32'h000000CD};
      vecs[6]  = '{3'b000, 32'h101, 32'h80AB7F12, 2, 1'b0, 32'h100, 32'h0000007F};
      vecs[7]  = '{3'b010, 32'h200, 32'h00018000, 0, 1'b0, 32'h200, 32'hFFFF8000};
      vecs[8]  = '{3'b011, 32'h200, 32'h00017FFF, 0, 1'b0, 32'h200, 32'h00007FFF};
      vecs[9]  = '{3'b101, 32'h020, 32'h0,        0, 1'b1, 32'h0,   32'h0};
      vecs[10] = '{3'b001, 32'h102, 32'h80AB7F12, 0, 1'b0, 32'h100, 32'h000000AB};
`ifdef LOAD_MISALIGN_TRAP_EN
      vecs[11] = '{3'b100, 32'h041, 32'hDEADBEEF, 0, 1'b1, 32'h0,   32'h0};
      vecs[12] = '{3'b011, 32'h203, 32'hFEDC0000, 0, 1'b1, 32'h0,   32'h0};
`else
      vecs[11] = '{3'b100, 32'h041, 32'hDEADBEEF, 0, 1'b0, 32'h040, 32'hDEADBEEF};
      vecs[12] = '{3'b011, 32'h203, 32'hFEDC0000, 0, 1'b0, 32'h200, 32'h0000FEDC};
`endif
      vecs[13] = '{3'b110, 32'h030, 32'h0,        0, 1'b1, 32'h0,   32'h0};

      rst_n     = 1'b0;
      ld_valid  = 1'b0;
      ld_type   = 3'b000;
      ld_addr   = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      last_good = 32'h0;

      #3;
      check("rst ld_ready", {31'd0, ld_ready}, 32'd1);
      check("rst mem_req", {31'd0, mem_req}, 32'd0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst rd_data", rd_data, 32'h0);
      check("rst ld_err", {31'd0, ld_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // stray ack in IDLE must not produce a result
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("idle ack rd_valid", {31'd0, rd_valid}, 32'd0);
      check("idle ack rd_data", rd_data, 32'h0);
      check("idle ack ready", {31'd0, ld_ready}, 32'd1);

      for (int i = 0; i < 14; i++)
         run_vec(i, vecs[i]);

      // ld_valid while busy is ignored and does not disturb mem_addr
      @(negedge clk);
      ld_valid = 1'b1; ld_type = 3'b100; ld_addr = 32'h300;
      @(posedge clk);
      #1 ld_type = 3'b000; ld_addr = 32'h503;
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         check("busy addr", mem_addr, 32'h300);
         check("busy req", {31'd0, mem_req}, 32'd1);
      end
      ld_valid  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("busy rd_data", rd_data, 32'hCAFEF00D);
      @(negedge clk);
      check("busy no second req", {31'd0, mem_req}, 32'd0);
      check("busy idle", {31'd0, ld_ready}, 32'd1);

      // reset during REQ abandons the access; late ack ignored
      @(negedge clk);
      ld_valid = 1'b1; ld_type = 3'b100; ld_addr = 32'h80;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      @(negedge clk);
      check("pre-rst req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async rst mem_req", {31'd0, mem_req}, 32'd0);
      check("async rst ready", {31'd0, ld_ready}, 32'd1);
      check("async rst mem_addr", mem_addr, 32'h0);
      check("async rst rd_data", rd_data, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA55AA;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("late ack rd_valid", {31'd0, rd_valid}, 32'd0);
      check("late ack rd_data", rd_data, 32'h0);
      check("late ack mem_req", {31'd0, mem_req}, 32'd0);
      check("late ack ready", {31'd0, ld_ready}, 32'd1);
      check("late ack ld_err", {31'd0, ld_err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of ld_addr and mem_addr.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 ld_valid  input  1  load request strobe from the pipeline.
REQ-005 ld_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 ld_type  input  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101-111 illegal.
REQ-007 ld_addr  input  ADDR_W  byte address of the load.
REQ-008 mem_req  output  1  read request to data memory, held until acknowledged.
REQ-009 mem_addr  output  ADDR_W  word-aligned address: {ld_addr[ADDR_W-1:2],2'b00}.
REQ-010 mem_ack  input  1  memory read data valid this cycle.
REQ-011 mem_rdata  input  32  little-endian memory word; byte 0 is bits [7:0].
REQ-012 rd_valid  output  1  one-cycle pulse: rd_data is valid.
REQ-013 rd_data  output  32  extracted, extended load result.
REQ-014 ld_err  output  1  one-cycle pulse: request rejected (illegal type or trapped misalignment).

Function
REQ-015 FSM states are IDLE, REQ, DONE; ld_valid&&ld_ready in IDLE SHALL latch ld_type and ld_addr[1:0] and move to REQ next cycle.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr SHALL stay constant until the cycle mem_ack=1.
REQ-017 mem_ack=1 in REQ SHALL capture the extracted result into rd_data and move to DONE; mem_ack outside REQ SHALL be ignored.
REQ-018 DONE SHALL assert rd_valid for exactly one cycle, then return to IDLE; ld_ready SHALL be 0 in DONE.
REQ-019 Latency: request accepted at edge N -> mem_req high during cycle N+1; mem_ack at edge M -> rd_valid high during cycle M+1; minimum request-to-result is 2 cycles.
REQ-020 Byte select: addr[1:0]=0,1,2,3 selects mem_rdata[7:0],[15:8],[23:16],[31:24].
REQ-021 Halfword select: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
REQ-022 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass mem_rdata unchanged.
REQ-023 Illegal ld_type SHALL issue no mem_req, pulse ld_err for one cycle in place of REQ, and return to IDLE with rd_data unchanged.
REQ-024 rd_data SHALL hold its last value outside DONE; ld_valid arriving when ld_ready=0 SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL force IDLE, mem_req=0, mem_addr=0, rd_valid=0, rd_data=0, ld_err=0, ld_ready=1 immediately.
REQ-026 Reset during REQ SHALL abandon the access; a mem_ack arriving after reset release SHALL be ignored.

Configuration
REQ-027 Macro LOAD_MISALIGN_TRAP_EN: when defined, LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 SHALL be treated as in REQ-023 (no mem_req, ld_err pulse).
REQ-028 When LOAD_MISALIGN_TRAP_EN is undefined, low address bits SHALL be silently ignored for the selected width (LH uses addr[1] only; LW ignores addr[1:0]) and ld_err SHALL fire only for illegal ld_type.

Verification
REQ-029 LB at addr 0x103, mem_rdata=0x80AB_CD12, mem_ack after 1 cycle -> mem_addr=0x100, rd_data=0xFFFF_FF80, rd_valid one cycle.
REQ-030 LHU at addr 0x202, mem_rdata=0x9ABC_1234 -> rd_data=0x0000_9ABC; LH same -> 0xFFFF_9ABC.
REQ-031 LW at 0x40, mem_ack delayed 5 cycles -> mem_req held 5 cycles, mem_addr stable, rd_data=mem_rdata, ld_ready=0 throughout.
REQ-032 ld_type=111 -> no mem_req, ld_err pulses 1 cycle, rd_data unchanged, back to IDLE.
REQ-033 LW at 0x41 with LOAD_MISALIGN_TRAP_EN defined -> ld_err pulse, no mem_req; undefined -> mem_addr=0x40, normal result.
REQ-034 rst_n low during REQ, then mem_ack after release -> IDLE, all outputs at reset values, no rd_valid.
